// File: rtl/backscatter_fsk_scheduler_if.sv
// Byte-stream handshake into the backscatter FSK scheduler.
// The source drives data/valid/last and the scheduler answers with ready.
interface backscatter_fsk_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/backscatter_fsk_scheduler.sv
// Frame sequencer for the backscatter tag: PREAMBLE -> DATA (MSB first) -> silent GUARD, as FSK on mod_out.
// Optional macro BACKSCATTER_IDLE_TONE_EN: free-running DIV0 tone on mod_out while IDLE.
module backscatter_fsk_scheduler #(
  parameter int unsigned DIV0          = 3072,
  parameter int unsigned DIV1          = 6144,
  parameter int unsigned BIT_CYCLES    = 24576,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter logic [31:0] PREAMBLE_PAT  = 32'hAA,
  parameter int unsigned GUARD_CYCLES  = 12000
) (
  input  logic                              clk_12M,
  input  logic                              rst_n_in,
  backscatter_fsk_scheduler_if.slave        tx,
  output logic                              mod_out,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              underrun
);

  localparam int unsigned CNT_MAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_MAX = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned TONE_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned IDX_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [TONE_W-1:0] DIV0_LAST  = TONE_W'(DIV0 - 1);
  localparam logic [TONE_W-1:0] DIV1_LAST  = TONE_W'(DIV1 - 1);
  localparam logic [IDX_W-1:0]  PRE_LAST   = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0]  BYTE_LAST  = IDX_W'(7);
  // Preamble is left-aligned so bit 31 is always the bit on air.
  localparam logic [31:0]       PRE_INIT   = PREAMBLE_PAT << (32 - PREAMBLE_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_GUARD
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       pre_sh_q, pre_sh_d;
  logic [7:0]        shift_q, shift_d;
  logic              shift_last_q, shift_last_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_vld_q, hold_vld_d;
  logic              mod_q, mod_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;

  logic ready;
  logic xfer;
  logic cur_bit;
  logic tone_last;
  logic slot_end;
  logic start_slot;
  logic load_shift;

  assign ready       = !hold_vld_q && (state_q != S_GUARD);
  assign tx.tx_ready = ready;
  assign xfer        = tx.tx_valid && ready;
  assign cur_bit     = (state_q == S_PREAMBLE) ? pre_sh_q[31] : shift_q[7];
  assign tone_last   = cur_bit ? (tone_q == DIV1_LAST) : (tone_q == DIV0_LAST);
  assign slot_end    = (cnt_q == BIT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tone_d       = tone_q;
    idx_d        = idx_q;
    pre_sh_d     = pre_sh_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_vld_d   = hold_vld_q;
    mod_d        = mod_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    start_slot   = 1'b0;
    load_shift   = 1'b0;

    // Mid-slot tone generation; slot boundaries below override it.
    if ((state_q == S_PREAMBLE) || (state_q == S_DATA)) begin
      cnt_d = cnt_q + 1'b1;
      if (tone_last) begin
        tone_d = '0;
        mod_d  = ~mod_q;
      end else begin
        tone_d = tone_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
`ifdef BACKSCATTER_IDLE_TONE_EN
        if (tone_q == DIV0_LAST) begin
          tone_d = '0;
          mod_d  = ~mod_q;
        end else begin
          tone_d = tone_q + 1'b1;
        end
`else
        tone_d = '0;
        mod_d  = 1'b0;
`endif
        if (hold_vld_q) begin
          state_d    = S_PREAMBLE;
          idx_d      = '0;
          pre_sh_d   = PRE_INIT;
          start_slot = 1'b1;
        end
      end

      S_PREAMBLE: begin
        if (slot_end) begin
          start_slot = 1'b1;
          if (idx_q == PRE_LAST) begin
            state_d    = S_DATA;
            idx_d      = '0;
            load_shift = 1'b1;
          end else begin
            idx_d    = idx_q + 1'b1;
            pre_sh_d = {pre_sh_q[30:0], 1'b0};
          end
        end
      end

      S_DATA: begin
        if (slot_end) begin
          if (idx_q != BYTE_LAST) begin
            idx_d      = idx_q + 1'b1;
            shift_d    = {shift_q[6:0], 1'b0};
            start_slot = 1'b1;
          end else if (!shift_last_q && hold_vld_q) begin
            idx_d      = '0;
            load_shift = 1'b1;
            start_slot = 1'b1;
          end else begin
            // Either the frame ended cleanly or the next byte never arrived.
            state_d    = S_GUARD;
            idx_d      = '0;
            cnt_d      = '0;
            tone_d     = '0;
            mod_d      = 1'b0;
            underrun_d = !shift_last_q;
          end
        end
      end

      S_GUARD: begin
        mod_d = 1'b0;
        if (cnt_q == GUARD_LAST) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every bit slot restarts the subcarrier phase high.
    if (start_slot) begin
      cnt_d  = '0;
      tone_d = '0;
      mod_d  = 1'b1;
    end

    if (load_shift) begin
      shift_d      = hold_q;
      shift_last_d = hold_last_q;
      hold_vld_d   = 1'b0;
    end

    if (xfer) begin
      hold_d      = tx.tx_data;
      hold_last_d = tx.tx_last;
      hold_vld_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_12M) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tone_q       <= '0;
      idx_q        <= '0;
      pre_sh_q     <= '0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_vld_q   <= 1'b0;
      mod_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tone_q       <= tone_d;
      idx_q        <= idx_d;
      pre_sh_q     <= pre_sh_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_vld_q   <= hold_vld_d;
      mod_q        <= mod_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mod_out    = mod_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_backscatter_fsk_scheduler.sv
// Self-checking bench for backscatter_fsk_scheduler with small bench parameters.
// Expected waveforms come from a bit-list model: each bit slot is a square wave of half-period DIVx starting high.
module tb_backscatter_fsk_scheduler;
  localparam int unsigned DIV0       = 2;
  localparam int unsigned DIV1       = 4;
  localparam int unsigned BIT_CYCLES = 8;
  localparam int unsigned PRE_BITS   = 4;
  localparam logic [31:0] PAT        = 32'hA;
  localparam int unsigned GUARD      = 3;
  localparam int          PRE_LEN    = PRE_BITS * BIT_CYCLES;
  localparam int          BYTE_LEN   = 8 * BIT_CYCLES;

  logic clk_12M = 1'b0;
  logic rst_n_in = 1'b0;
  logic mod_out, busy, frame_done, underrun;

  backscatter_fsk_scheduler_if tx_if ();

  backscatter_fsk_scheduler #(
    .DIV0(DIV0), .DIV1(DIV1), .BIT_CYCLES(BIT_CYCLES),
    .PREAMBLE_BITS(PRE_BITS), .PREAMBLE_PAT(PAT), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk_12M(clk_12M), .rst_n_in(rst_n_in), .tx(tx_if.slave),
    .mod_out(mod_out), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk_12M = ~clk_12M;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] src_q[$];      // {last, data} waiting at the source
  logic [8:0] acc_q[$];      // bytes that completed a handshake
  int         acc_idx[$];    // record index at which each handshake completed
  logic       rec_mod[$], rec_busy[$], rec_ur[$], rec_fd[$], rec_rdy[$];
  logic [7:0] exp_bytes[$];
  logic       exp_mod[$];

  function automatic logic slot_level(input logic b, input int k);
    int half;
    half = b ? int'(DIV1) : int'(DIV0);
    return ((k / half) % 2) == 0;
  endfunction

  // Whole-frame reference: preamble bits, data bits MSB first, then silent guard.
  function automatic void model_frame();
    logic [31:0] pat;
    logic [7:0]  by;
    pat = PAT;
    exp_mod.delete();
    for (int i = PRE_BITS - 1; i >= 0; i--)
      for (int k = 0; k < int'(BIT_CYCLES); k++) exp_mod.push_back(slot_level(pat[i], k));
    foreach (exp_bytes[n]) begin
      by = exp_bytes[n];
      for (int j = 7; j >= 0; j--)
        for (int k = 0; k < int'(BIT_CYCLES); k++) exp_mod.push_back(slot_level(by[j], k));
    end
    for (int g = 0; g < int'(GUARD); g++) exp_mod.push_back(1'b0);
  endfunction

  task automatic drive_next();
    if (src_q.size() > 0) begin
      tx_if.tx_valid = 1'b1;
      {tx_if.tx_last, tx_if.tx_data} = src_q[0];
    end else begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_last  = 1'b0;
      tx_if.tx_data  = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_12M);
      #1;
    end
  endtask

  // Runs the source and records outputs (sampled 1 time unit after each edge) until frame_done or budget.
  task automatic run_frame(input int max_cycles, output bit done);
    bit xfer;
    bit fin;
    fin = 1'b0;
    rec_mod.delete(); rec_busy.delete(); rec_ur.delete(); rec_fd.delete(); rec_rdy.delete();
    acc_idx.delete();
    drive_next();
    for (int c = 0; c < max_cycles && !fin; c++) begin
      xfer = tx_if.tx_valid && tx_if.tx_ready;
      @(posedge clk_12M);
      #1;
      if (xfer) begin
        acc_q.push_back(src_q.pop_front());
        acc_idx.push_back(rec_mod.size());
      end
      rec_mod.push_back(mod_out);
      rec_busy.push_back(busy);
      rec_ur.push_back(underrun);
      rec_fd.push_back(frame_done);
      rec_rdy.push_back(tx_if.tx_ready);
      if (frame_done === 1'b1) fin = 1'b1;
      drive_next();
    end
    done = fin;
  endtask

  // Tallies deviations of the recording from exp_mod; callers judge the tallies.
  task automatic score_frame(output int s, output int wave_err, output int end_idx,
                             output int ur_idx, output int ur_cnt, output int rdy_err);
    int len;
    s = -1; end_idx = -1; ur_idx = -1; ur_cnt = 0; wave_err = 0; rdy_err = 0;
    foreach (rec_busy[i]) begin
      if (s < 0 && rec_busy[i] === 1'b1) s = i;
      if (end_idx < 0 && rec_fd[i] === 1'b1) end_idx = i;
      if (rec_ur[i] === 1'b1) begin
        ur_cnt++;
        if (ur_idx < 0) ur_idx = i;
      end
    end
    if (s < 0) begin
      wave_err = 1;
      return;
    end
    len = exp_mod.size();
    for (int k = 0; k < len; k++) begin
      if (s + k >= rec_mod.size()) wave_err++;
      else begin
        if (rec_mod[s + k] !== exp_mod[k] || rec_busy[s + k] !== 1'b1) wave_err++;
        if ((k < PRE_LEN || k >= len - int'(GUARD)) && rec_rdy[s + k] !== 1'b0) rdy_err++;
      end
    end
`ifndef BACKSCATTER_IDLE_TONE_EN
    for (int i = 0; i < s; i++) if (rec_mod[i] !== 1'b0) wave_err++;
    for (int i = s + len; i < rec_mod.size(); i++) if (rec_mod[i] !== 1'b0) wave_err++;
`endif
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    src_q.delete();
    drive_next();
    @(posedge clk_12M);
    #1;
    n_cmp++; if (mod_out !== 1'b0) begin n_err++; $display("FAIL reset_mod_out: got %b want 0", mod_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (tx_if.tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", tx_if.tx_ready); end
    rst_n_in = 1'b1;
    idle(2);
  endtask

  task automatic test_single_byte();
    bit done;
    int s, we, ei, ui, uc, re;
    idle($urandom_range(0, 5));
    acc_q.delete();
    src_q.push_back({1'b1, 8'hA5});
    exp_bytes = '{8'hA5};
    model_frame();
    run_frame(300, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if (acc_idx.size() !== 1) begin n_err++; $display("FAIL single_accepts: got %0d want 1", acc_idx.size()); end
    else begin
      n_cmp++; if (s !== acc_idx[0] + 1) begin n_err++; $display("FAIL single_start_latency: got %0d want %0d", s, acc_idx[0] + 1); end
    end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL single_waveform: got %0d bad cycles want 0", we); end
    n_cmp++; if (ei - s !== 99) begin n_err++; $display("FAIL single_busy_len: got %0d want 99", ei - s); end
    if (ei >= 0) begin
      n_cmp++; if (rec_busy[ei] !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", rec_busy[ei]); end
    end
    n_cmp++; if (uc !== 0) begin n_err++; $display("FAIL single_underrun: got %0d pulses want 0", uc); end
    n_cmp++; if (re !== 0) begin n_err++; $display("FAIL single_ready_blocked: got %0d bad cycles want 0", re); end
  endtask

  task automatic test_back_to_back();
    bit done;
    int s, we, ei, ui, uc, re;
    idle($urandom_range(1, 4));
    acc_q.delete();
    src_q.push_back({1'b0, 8'h00});
    src_q.push_back({1'b1, 8'hFF});
    exp_bytes = '{8'h00, 8'hFF};
    model_frame();
    run_frame(400, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done); end
    n_cmp++; if (acc_idx.size() !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc_idx.size()); end
    else begin
      n_cmp++; if (acc_idx[1] !== s + PRE_LEN + 1) begin n_err++; $display("FAIL b2b_second_accept: got %0d want %0d", acc_idx[1], s + PRE_LEN + 1); end
    end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL b2b_waveform: got %0d bad cycles want 0", we); end
    n_cmp++; if (ei - s !== PRE_LEN + 2 * BYTE_LEN + int'(GUARD)) begin
      n_err++; $display("FAIL b2b_busy_len: got %0d want %0d", ei - s, PRE_LEN + 2 * BYTE_LEN + int'(GUARD)); end
    n_cmp++; if (uc !== 0) begin n_err++; $display("FAIL b2b_underrun: got %0d pulses want 0", uc); end
  endtask

  task automatic test_underrun();
    bit done;
    int s, we, ei, ui, uc, re;
    idle($urandom_range(1, 4));
    acc_q.delete();
    src_q.push_back({1'b0, 8'h01});
    exp_bytes = '{8'h01};
    model_frame();
    run_frame(300, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL underrun_done: got %b want 1", done); end
    n_cmp++; if (uc !== 1) begin n_err++; $display("FAIL underrun_pulses: got %0d want 1", uc); end
    n_cmp++; if (ui - s !== 96) begin n_err++; $display("FAIL underrun_cycle: got %0d want 96", ui - s); end
    n_cmp++; if (ei - s !== 99) begin n_err++; $display("FAIL underrun_done_cycle: got %0d want 99", ei - s); end
    if (ei >= 0) begin
      n_cmp++; if (rec_busy[ei] !== 1'b0) begin n_err++; $display("FAIL underrun_busy_fall: got %b want 0", rec_busy[ei]); end
    end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL underrun_waveform: got %0d bad cycles want 0", we); end
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    int s, we, ei, ui, uc, re;
    logic [7:0] b;
    acc_q.delete();
    src_q.push_back({1'b1, 8'($urandom_range(0, 255))});
    // Accept on the first edge, busy from the next, so 60 samples end inside data bit 3.
    run_frame(60, done);
    n_cmp++; if (rec_busy[59] !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", rec_busy[59]); end
    rst_n_in = 1'b0;
    @(posedge clk_12M);
    #1;
    rst_n_in = 1'b1;
    n_cmp++; if (mod_out !== 1'b0) begin n_err++; $display("FAIL rstmid_mod_out: got %b want 0", mod_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (tx_if.tx_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_if.tx_ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
    b = 8'($urandom_range(0, 255));
    src_q.push_back({1'b1, b});
    exp_bytes = '{b};
    model_frame();
    run_frame(300, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_new_done: got %b want 1", done); end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL rstmid_new_waveform: got %0d bad cycles want 0", we); end
    n_cmp++; if (ei - s !== 99) begin n_err++; $display("FAIL rstmid_new_busy_len: got %0d want 99", ei - s); end
  endtask

  task automatic test_full_stream();
    bit done;
    int s, we, ei, ui, uc, re, n, pat_err;
    logic [8:0] sent[$];
    logic [7:0] nxt;
    idle($urandom_range(1, 4));
    acc_q.delete();
    exp_bytes.delete();
    n = $urandom_range(2, 3);
    for (int i = 0; i < n; i++) begin
      exp_bytes.push_back(8'($urandom_range(0, 255)));
      sent.push_back({(i == n - 1), exp_bytes[i]});
    end
    nxt = 8'($urandom_range(0, 255));
    sent.push_back({1'b1, nxt});
    foreach (sent[i]) src_q.push_back(sent[i]);
    model_frame();
    run_frame(600, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stream_done: got %b want 1", done); end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL stream_waveform: got %0d bad cycles want 0", we); end
    n_cmp++; if (re !== 0) begin n_err++; $display("FAIL stream_ready_pre_guard: got %0d bad cycles want 0", re); end
    n_cmp++; if (uc !== 0) begin n_err++; $display("FAIL stream_underrun: got %0d pulses want 0", uc); end
    // With data always waiting, the hold is empty only on the first cycle of each data byte.
    pat_err = 0;
    for (int c = 0; c < n * BYTE_LEN; c++)
      if (s >= 0 && s + PRE_LEN + c < rec_rdy.size() && rec_rdy[s + PRE_LEN + c] !== ((c % BYTE_LEN) == 0)) pat_err++;
    n_cmp++; if (pat_err !== 0) begin n_err++; $display("FAIL stream_ready_pattern: got %0d bad cycles want 0", pat_err); end
    exp_bytes = '{nxt};
    model_frame();
    run_frame(300, done);
    score_frame(s, we, ei, ui, uc, re);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stream2_done: got %b want 1", done); end
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL stream2_start: got %0d want 0", s); end
    n_cmp++; if (we !== 0) begin n_err++; $display("FAIL stream2_waveform: got %0d bad cycles want 0", we); end
    n_cmp++; if (acc_q.size() !== sent.size()) begin n_err++; $display("FAIL stream_accept_count: got %0d want %0d", acc_q.size(), sent.size()); end
    else
      foreach (sent[i]) begin
        n_cmp++; if (acc_q[i] !== sent[i]) begin n_err++; $display("FAIL stream_byte%0d: got %h want %h", i, acc_q[i], sent[i]); end
      end
  endtask

  task automatic test_idle_tone();
    logic m[20];
    int err;
    int ones;
    src_q.delete();
    drive_next();
    err = 0;
    ones = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_12M);
      #1;
      m[t] = mod_out;
      if (m[t] === 1'b1) ones++;
    end
`ifdef BACKSCATTER_IDLE_TONE_EN
    for (int t = 4; t < 20; t++) if (m[t] !== m[t - 4] || m[t] === m[t - 2]) err++;
    n_cmp++; if (ones !== 10) begin n_err++; $display("FAIL idle_tone_duty: got %0d high cycles want 10", ones); end
`else
    for (int t = 0; t < 20; t++) if (m[t] !== 1'b0) err++;
    n_cmp++; if (ones !== 0) begin n_err++; $display("FAIL idle_quiet_high: got %0d high cycles want 0", ones); end
`endif
    n_cmp++; if (err !== 0) begin n_err++; $display("FAIL idle_tone_shape: got %0d bad cycles want 0", err); end
  endtask

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_last  = 1'b0;
    tx_if.tx_data  = 8'h00;
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_full_stream();
    test_idle_tone();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
